// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel framer: FSM state encoding
// and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd2,
    PARITY = 2'd3
  } state_e;

  // Counter must be able to represent 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nonblock.sv
// Practice D flip-flop cell (non-blocking form). Its registered q is the
// serial stream fed into sipo_framer.
module nonblock (
  input  logic clk,
  input  logic d,
  output logic q
);

  // Plain rising-edge register.
  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: start strobe opens a frame, each d_en strobe
// shifts one bit in (MSB first), the completed word is held under a
// valid/ready handshake with a sticky overrun flag.
// Optional feature: define SIPO_PARITY_EN to sample a trailing even-parity
// bit and report parity_err with the held word.
module sipo_framer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             d_en,
  input  logic             start,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Only WIDTH-1 bits need to be kept; the incoming bit completes the word.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] next_word;

`ifdef SIPO_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  assign next_word = {shreg_q, d_in};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
`ifdef SIPO_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        if (d_en) begin
          shreg_d = next_word[WIDTH-2:0];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_out_d = next_word;
`ifdef SIPO_PARITY_EN
            state_d    = PARITY;
`else
            state_d      = HOLD;
            data_valid_d = 1'b1;
`endif
          end
        end
      end

`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (d_en) begin
          // data_out_q already holds the completed word here.
          parity_err_d = (^data_out_q) ^ d_in;
          data_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
`endif

      HOLD: begin
        if (data_ready) begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
          overrun_d    = start;
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT) || (state_d == PARITY);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity flag register, loaded alongside data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_framer.sv
// Directed self-checking bench for sipo_framer, driven through a nonblock
// flip-flop. Expected words are queued when a frame is driven and popped
// when data_valid is observed.
module tb_sipo_framer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         ff_d;
  logic         ff_q;
  logic         d_en;
  logic         start;
  logic         data_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  // {expected parity_err, expected word}
  logic [W:0] exp_q[$];

  nonblock u_ff (
    .clk (clk),
    .d   (ff_d),
    .q   (ff_q)
  );

  sipo_framer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (ff_q),
    .d_en       (d_en),
    .start      (start),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("accept_valid", 32'(data_valid), 32'd0);
  endtask

  // Drives one frame with d_en held high (also during the start cycle, where
  // it must be ignored); stall_after inserts three idle cycles after that
  // many bits.
  task automatic frame(input logic [W-1:0] word, input int stall_after, input logic par);
    logic [W:0] seq;
    logic [W:0] exp;
    logic       exp_par;
    int         n;
    seq = {word, par};
`ifdef SIPO_PARITY_EN
    n       = W + 1;
    exp_par = (^word) ^ par;
`else
    n       = W;
    exp_par = 1'b0;
`endif
    exp_q.push_back({exp_par, word});

    ff_d  = seq[W];
    start = 1'b1;
    d_en  = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(data_valid), 32'd0);

    for (int i = 0; i < n; i++) begin
      ff_d = (i + 1 < n) ? seq[W-1-i] : 1'b0;
      d_en = 1'b1;
      tick();
      d_en = 1'b0;
      if (i < n - 1) begin
        chk("shift_busy", 32'(busy), 32'd1);
        chk("shift_valid", 32'(data_valid), 32'd0);
      end
      if (i + 1 == stall_after) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_busy", 32'(busy), 32'd1);
        end
      end
    end

    chk("done_valid", 32'(data_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk("data_out", 32'(data_out), 32'(exp[W-1:0]));
      chk("parity_err", 32'(parity_err), 32'(exp[W]));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ff_d       = 1'b0;
    d_en       = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_parity", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(data_valid), 32'd0);

    // Basic frame
    frame(8'hB2, 0, 1'b0);
    accept();
    chk("data_out_kept", 32'(data_out), 32'hB2);

    // Stall between bits 4 and 5
    frame(8'hB2, 4, 1'b0);
    accept();

    // Overrun while holding
    frame(8'hB2, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    chk("ovr_data", 32'(data_out), 32'hB2);
    chk("ovr_busy", 32'(busy), 32'd0);
    tick();
    chk("ovr_discard_busy", 32'(busy), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    accept();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Start and ready on the same edge
    frame(8'hC5, 0, 1'b1);
    start      = 1'b1;
    data_ready = 1'b1;
    tick();
    start      = 1'b0;
    data_ready = 1'b0;
    chk("sr_valid", 32'(data_valid), 32'd0);
    chk("sr_overrun", 32'(overrun), 32'd1);
    chk("sr_busy", 32'(busy), 32'd0);
    tick();
    chk("sr_discard_busy", 32'(busy), 32'd0);

    // Reset mid-frame after 5 bits
    ff_d  = 1'b1;
    start = 1'b1;
    d_en  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    d_en = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    frame(8'h5A, 0, 1'b0);
    accept();
    chk("post_rst_overrun", 32'(overrun), 32'd0);

    // Boundary words
    frame(8'h81, 3, 1'b0);
    accept();
    frame(8'hFF, 0, 1'b0);
    accept();

`ifdef SIPO_PARITY_EN
    frame(8'hB2, 0, 1'b0);
    accept();
    frame(8'hB2, 0, 1'b1);
    accept();
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_framer.md
# sipo_framer

Serial-to-parallel framing stage that sits directly downstream of the practice D flip-flop cells (`block` / `nonblock`): it consumes their registered serial `q` stream and assembles it into a parallel word. Each frame is started by a `start` strobe and advanced one bit per `d_en` strobe. The completed word is held under a valid/ready handshake for the next consumer, with overrun and (optionally) parity reporting.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per frame, legal range 2..32.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `d_in` input 1: serial data bit, typically the upstream flip-flop `q`.
- `d_en` input 1: bit-sample strobe; `d_in` is taken on the rising edge where `d_en`=1.
- `start` input 1: frame-start strobe.
- `data_ready` input 1: consumer accepts the held word.
- `data_out` output WIDTH: assembled word, MSB received first.
- `data_valid` output 1: `data_out` holds a complete, unaccepted frame.
- `busy` output 1: a frame is being shifted in.
- `overrun` output 1: sticky flag; a `start` arrived while a word was held.
- `parity_err` output 1: parity mismatch on the held word. This port is always present.

## Operation
- The state machine has three states, IDLE, SHIFT and HOLD, plus a PARITY state when the macro is enabled.
- **IDLE**
  - `start`=1 moves to SHIFT on the next cycle and clears the bit counter.
  - `d_en` is ignored in IDLE, including in the `start` cycle.
- **SHIFT**
  - On each `d_en`=1 edge: shift register ← {shreg[WIDTH-2:0], d_in}, and the counter increments.
  - The counter is $clog2(WIDTH+1) bits wide.
  - When the counter reaches WIDTH-1 and `d_en`=1, that edge shifts in the last bit.
  - Next state is HOLD, or PARITY if enabled. `data_out` loads the completed register on that same edge.
  - `start` in SHIFT is ignored; there is no restart.
- **HOLD**
  - `data_valid`=1. `data_out` and `parity_err` are stable.
  - `data_valid`&&`data_ready` returns to IDLE on the next cycle.
  - `start` with `data_ready`=0 sets `overrun`; the start is discarded.
  - `start` and `data_ready` in the same cycle: the handshake completes, the state goes to IDLE, the start is discarded, and `overrun` is set.
- **`overrun`**: clears on the edge where a held word is accepted, unless `start` is also present on that edge.
- **`data_out`** keeps its last value after acceptance until the next frame completes.
- **`busy`** is 1 only in SHIFT and PARITY.

## Timing
- All outputs are registered.
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0, state=IDLE.
- `start` at edge n → `busy`=1 after edge n. The first bit is sampled at the first `d_en` edge after n.
- Last data bit at edge m → `data_valid`=1 after edge m (without PARITY).
- Latency from the first bit edge to `data_valid` is WIDTH-1 `d_en` edges plus 0 extra cycles.
- Acceptance at edge k → `data_valid`=0 after k. The earliest new `start` is sampled at edge k+1.
- Back-to-back frames with `d_en` held at 1: WIDTH+2 cycles per frame without PARITY, WIDTH+3 with it.
- Gaps in `d_en` during SHIFT are allowed and just stall the frame.
- `rst_n` asserted mid-frame or in HOLD: immediate return to reset values. The partial frame is lost.

## Configuration
- `SIPO_PARITY_EN` defined:
  - After the last data bit, the block enters PARITY.
  - The next `d_en` edge samples the parity bit.
  - `parity_err` = ^{data, parity bit} (even parity), registered into HOLD with `data_valid`.
- `SIPO_PARITY_EN` undefined:
  - There is no PARITY state.
  - `parity_err` is tied to 0.

## Structure
- Shared package `sipo_pkg`:
  - state encoding localparams (IDLE=0, SHIFT=1, HOLD=2, PARITY=3);
  - the counter-width function.
- No sub-module. The shift register, counter and FSM live in one module.
- The bench instantiates `sipo_framer` fed from a `nonblock` flip-flop output.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → all outputs 0. Release → IDLE, `busy`=0.
- **Basic frame:** WIDTH=8, `start`, then 8 `d_en` bits 1,0,1,1,0,0,1,0 → `data_out`=8'hB2, `data_valid`=1 one cycle after the 8th bit. `data_ready`=1 → `data_valid`=0 next cycle.
- **Stall:** same bits with `d_en` low for 3 cycles between bits 4 and 5 → same 8'hB2 result, and `busy` stays 1 throughout.
- **Overrun:** hold the word with `data_ready`=0 and pulse `start` → `overrun`=1, `data_out` unchanged at 8'hB2. Accept the word → `overrun`=0.
- **Reset mid-frame:** assert `rst_n`=0 after 5 bits → `busy`=0 immediately. A new full frame 8'h5A then completes correctly.
- **Parity (`SIPO_PARITY_EN`):** data 8'hB2 with parity bit 0 → `parity_err`=0. Data 8'hB2 with parity bit 1 → `parity_err`=1 alongside `data_valid`.
